trigonometry_deg: RTL and testbench

TRIGONOMETRY_DEG -- requirements
Module: trigonometry_deg

---
 rtl/trig_deg_pkg.sv | 29 ++
 rtl/trig_deg_reduce.sv | 38 +++
 rtl/trigonometry_deg.sv | 93 +++++++++
 tb/tb_trigonometry_deg.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/trig_deg_pkg.sv
// Shared constants for the degree-based trig block: Q12 scale, quarter-wave sine table, quadrant type.
// Table entry k is round-half-away-from-zero(4096*sin(k deg)), k = 0..90.
package trig_deg_pkg;

    localparam int TRIG_SCALE = 4096;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_t;

    localparam logic [12:0] SIN_TABLE [0:90] = '{
        13'd0,    13'd71,   13'd143,  13'd214,  13'd286,  13'd357,  13'd428,  13'd499,
        13'd570,  13'd641,  13'd711,  13'd782,  13'd852,  13'd921,  13'd991,  13'd1060,
        13'd1129, 13'd1198, 13'd1266, 13'd1334, 13'd1401, 13'd1468, 13'd1534, 13'd1600,
        13'd1666, 13'd1731, 13'd1796, 13'd1860, 13'd1923, 13'd1986, 13'd2048, 13'd2110,
        13'd2171, 13'd2231, 13'd2290, 13'd2349, 13'd2408, 13'd2465, 13'd2522, 13'd2578,
        13'd2633, 13'd2687, 13'd2741, 13'd2793, 13'd2845, 13'd2896, 13'd2946, 13'd2996,
        13'd3044, 13'd3091, 13'd3138, 13'd3183, 13'd3228, 13'd3271, 13'd3314, 13'd3355,
        13'd3396, 13'd3435, 13'd3474, 13'd3511, 13'd3547, 13'd3582, 13'd3617, 13'd3650,
        13'd3681, 13'd3712, 13'd3742, 13'd3770, 13'd3798, 13'd3824, 13'd3849, 13'd3873,
        13'd3896, 13'd3917, 13'd3937, 13'd3956, 13'd3974, 13'd3991, 13'd4006, 13'd4021,
        13'd4034, 13'd4046, 13'd4056, 13'd4065, 13'd4074, 13'd4080, 13'd4086, 13'd4090,
        13'd4094, 13'd4095, 13'd4096
    };

endpackage

// File: rtl/trig_deg_reduce.sv
// Range check and reduction of a signed degree angle to quadrant (0..3) and offset (0..89).
// Purely combinational; out-of-range angles reduce to 0. Reduction assumes ANGLE_LIMIT <= 360.
module trig_deg_reduce
    import trig_deg_pkg::*;
#(
    parameter int ANGLE_LIMIT = 360
) (
    input  logic signed [31:0] theta_i,
    output logic [1:0]         quad_o,
    output logic [6:0]         offset_o
);

    logic       in_range;
    logic [8:0] angle;

    always_comb begin
        in_range = (theta_i <= ANGLE_LIMIT) && (theta_i >= -ANGLE_LIMIT);
        // Only the low 9 bits matter once the angle is within +/-360; the add wraps mod 512.
        angle    = theta_i[31] ? (theta_i[8:0] + 9'd360) : theta_i[8:0];
        if (!in_range || (angle == 9'd360)) begin
            angle = '0;
        end

        quad_o   = QUAD_0;
        offset_o = angle[6:0];
        if (angle >= 9'd270) begin
            quad_o   = QUAD_3;
            offset_o = 7'(angle - 9'd270);
        end else if (angle >= 9'd180) begin
            quad_o   = QUAD_2;
            offset_o = 7'(angle - 9'd180);
        end else if (angle >= 9'd90) begin
            quad_o   = QUAD_1;
            offset_o = 7'(angle - 9'd90);
        end
    end

endmodule

// File: rtl/trigonometry_deg.sv
// Q12 cos/sin of an integer-degree angle from a quarter-wave table; registered outputs, 1-cycle latency.
// Define TRIGONOMETRY_DEG_INPUT_REG_EN to register i_theta first (latency 2). No handshake.
module trigonometry_deg
    import trig_deg_pkg::*;
#(
    parameter int ANGLE_LIMIT = 360
) (
    input  logic               i_clock,
    input  logic               i_RESET,
    input  logic signed [31:0] i_theta,
    output logic signed [31:0] o_cos,
    output logic signed [31:0] o_sin
);

    logic signed [31:0] theta_in;
    logic [1:0]         quad;
    logic [6:0]         offset;
    logic signed [32:0] tab_fwd;
    logic signed [32:0] tab_rev;
    logic signed [32:0] cos_d;
    logic signed [32:0] sin_d;
    logic signed [31:0] cos_q;
    logic signed [31:0] sin_q;

`ifdef TRIGONOMETRY_DEG_INPUT_REG_EN
    logic signed [31:0] theta_q;

    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            theta_q <= '0;
        end else begin
            theta_q <= i_theta;
        end
    end

    assign theta_in = theta_q;
`else
    assign theta_in = i_theta;
`endif

    trig_deg_reduce #(
        .ANGLE_LIMIT (ANGLE_LIMIT)
    ) u_reduce (
        .theta_i  (theta_in),
        .quad_o   (quad),
        .offset_o (offset)
    );

    // Table values are widened before any negation so -4096 is representable.
    assign tab_fwd = $signed({20'd0, SIN_TABLE[offset]});
    assign tab_rev = $signed({20'd0, SIN_TABLE[7'd90 - offset]});

    always_comb begin
        sin_d = tab_fwd;
        cos_d = tab_rev;
        case (quad_t'(quad))
            QUAD_0: begin
                sin_d = tab_fwd;
                cos_d = tab_rev;
            end
            QUAD_1: begin
                sin_d = tab_rev;
                cos_d = -tab_fwd;
            end
            QUAD_2: begin
                sin_d = -tab_fwd;
                cos_d = -tab_rev;
            end
            QUAD_3: begin
                sin_d = -tab_rev;
                cos_d = tab_fwd;
            end
            default: begin
                sin_d = tab_fwd;
                cos_d = tab_rev;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            cos_q <= 32'(TRIG_SCALE);
            sin_q <= '0;
        end else begin
            cos_q <= 32'(cos_d);
            sin_q <= 32'(sin_d);
        end
    end

    assign o_cos = cos_q;
    assign o_sin = sin_q;

endmodule

// File: tb/tb_trigonometry_deg.sv
// Bench for trigonometry_deg: real-valued cos/sin reference with an angle delay line,
// checked every falling edge, plus hand-computed directed vectors.
module tb_trigonometry_deg;

`ifdef TRIGONOMETRY_DEG_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam real PI = 3.14159265358979323846;

    logic               i_clock = 1'b0;
    logic               i_RESET = 1'b0;
    logic signed [31:0] i_theta = 32'sd45;
    logic signed [31:0] o_cos;
    logic signed [31:0] o_sin;

    int n_checks = 0;
    int n_errors = 0;
    int pipe [2];

    trigonometry_deg #(
        .ANGLE_LIMIT (360)
    ) dut (
        .i_clock (i_clock),
        .i_RESET (i_RESET),
        .i_theta (i_theta),
        .o_cos   (o_cos),
        .o_sin   (o_sin)
    );

    always #5 i_clock = ~i_clock;

    function automatic int rnd_away(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        else          return -$rtoi(-x + 0.5);
    endfunction

    // Reference: out-of-range angles behave as 0; otherwise exact trig, rounded.
    function automatic void model(input int th, output int c, output int s);
        int  t;
        real a;
        t = th;
        if (t > 360 || t < -360) t = 0;
        a = real'(t) * PI / 180.0;
        c = rnd_away(4096.0 * $cos(a));
        s = rnd_away(4096.0 * $sin(a));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Angle delay line: the output reflects the angle presented LAT edges ago, and 0 after reset.
    always @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            pipe[0] = 0;
            pipe[1] = 0;
        end else begin
            pipe[1] = pipe[0];
            pipe[0] = i_theta;
        end
    end

    always @(negedge i_clock) begin
        int     ec, es;
        longint sq;
        model(pipe[LAT-1], ec, es);
        chk("model_cos", o_cos, ec);
        chk("model_sin", o_sin, es);
        sq = longint'(o_cos) * longint'(o_cos) + longint'(o_sin) * longint'(o_sin);
        n_checks++;
        if (sq > 64'sd16785408 || sq < 64'sd16769024) begin
            n_errors++;
            $display("FAIL sumsq: got %0d expected 16777216 +/- 8192", sq);
        end
    end

    task automatic apply_check(input string name, input int th, input int ec, input int es);
        i_theta = th;
        repeat (LAT) @(posedge i_clock);
        #1;
        chk({name, "_cos"}, o_cos, ec);
        chk({name, "_sin"}, o_sin, es);
    endtask

    int vth [14] = '{0, 30, 60, 90, 180, 270, -90, -1, 1, 360, -360, 361, -100000, 45};
    int vc  [14] = '{4096, 3547, 2048, 0, -4096, 0, 0, 4095, 4095, 4096, 4096, 4096, 4096, 2896};
    int vs  [14] = '{0, 2048, 3547, 4096, 0, -4096, -4096, -71, 71, 0, 0, 0, 0, 2896};

    initial begin
        repeat (3) @(posedge i_clock);
        #1;
        chk("rst_cos", o_cos, 4096);
        chk("rst_sin", o_sin, 0);
        i_RESET = 1'b1;
        repeat (LAT) @(posedge i_clock);
        #1;
        chk("first_cos", o_cos, 2896);
        chk("first_sin", o_sin, 2896);

        for (int i = 0; i < 14; i++) begin
            apply_check($sformatf("vec%0d", vth[i]), vth[i], vc[i], vs[i]);
        end
        apply_check("minint", 32'h8000_0000, 4096, 0);
        apply_check("maxint", 32'h7fff_ffff, 4096, 0);

        // Asynchronous reset pulse between edges with a steady 90 degree input.
        apply_check("pre_rst90", 90, 0, 4096);
        @(posedge i_clock);
        #1;
        chk("hold90_cos", o_cos, 0);
        #2 i_RESET = 1'b0;
        #1;
        chk("async_rst_cos", o_cos, 4096);
        chk("async_rst_sin", o_sin, 0);
        @(posedge i_clock);
        #2 i_RESET = 1'b1;
        #1;
        chk("post_rel_cos", o_cos, 4096);
        chk("post_rel_sin", o_sin, 0);
        repeat (LAT) @(posedge i_clock);
        #1;
        chk("rel90_cos", o_cos, 0);
        chk("rel90_sin", o_sin, 4096);

        // Exhaustive legal range; the falling-edge compare checks each result.
        for (int th = -360; th <= 360; th++) begin
            i_theta = th;
            @(posedge i_clock);
            #1;
        end
        for (int k = 0; k < 8; k++) begin
            i_theta = (k % 2 == 0) ? 361 + k * 1000 : -361 - k * 7;
            @(posedge i_clock);
            #1;
        end
        repeat (3) @(posedge i_clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
